// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// Module   : timer_counter
// Purpose  : Memory-mapped 32-bit down-counting timer (one TC window) with
//            one-shot / auto-reload modes and a maskable interrupt request.
//            Word map: 0 CTRL {IM, Mode[1:0], En}, 1 PRESET, 2 COUNT (RO),
//            3 reserved (reads 0, writes ignored).
// Options  : TC_AUTORELOAD_EN - when defined, Mode 01 reloads and restarts
//            after expiry; when undefined every mode behaves as one-shot.
// Revision : 1.0 - initial release
// ============================================================================
module timer_counter #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:2]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  // --------------------------------------------------------------------------
  // Register offsets and FSM encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_off_ctrl   = 2'd0;
  localparam logic [1:0] c_off_preset = 2'd1;
  localparam logic [1:0] c_off_count  = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  // CTRL bit positions
  localparam int c_bit_en = 0;
  localparam int c_bit_im = 3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]  state_q,    state_d;
  logic [3:0]  ctrl_q,     ctrl_d;
  logic [31:0] preset_q,   preset_d;
  logic [31:0] count_q,    count_d;
  logic        irq_flag_q, irq_flag_d;

  logic [1:0]  word_off;
  logic        en;
  logic        reload_sel;
  logic        cpu_wr_ctrl;
  logic        cpu_wr_preset;

  // The bridge hands over raw address bits [3:2]; the window is normally
  // 16-byte aligned so this subtraction folds away, but it keeps the offset
  // correct should the window ever sit on a non-16-byte word boundary.
  assign word_off = Addr - BASE[3:2];

  assign en            = ctrl_q[c_bit_en];
  assign cpu_wr_ctrl   = WE && (word_off == c_off_ctrl);
  assign cpu_wr_preset = WE && (word_off == c_off_preset);

`ifdef TC_AUTORELOAD_EN
  // Only Mode 01 reloads; 1x is treated like one-shot.
  assign reload_sel = (ctrl_q[2:1] == 2'b01);
`else
  // Mode bits stay writable/readable for software, but never select reload.
  assign reload_sel = 1'b0;
`endif

  // Next-state: FSM update first, then CPU writes override where they collide.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // preset_q is the pre-edge value, so a same-edge PRESET write is
        // only seen by the following LOAD.
        count_d = preset_q;
        state_d = ST_CNT;
      end

      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Covers both 1 and 0, so the counter never wraps below zero.
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end

      ST_INT: begin
        if (reload_sel) begin
          irq_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          ctrl_d[c_bit_en] = 1'b0;
          state_d          = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A CTRL store replaces the whole field (including En cleared by INT)
    // and acknowledges any pending interrupt on the same edge.
    if (cpu_wr_ctrl) begin
      ctrl_d     = Din[3:0];
      irq_flag_d = 1'b0;
    end

    if (cpu_wr_preset) begin
      preset_d = Din;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Zero-latency read mux; the bridge registers Dout with other load data.
  always_comb begin
    Dout = 32'd0;
    unique case (word_off)
      c_off_ctrl:   Dout = {28'd0, ctrl_q};
      c_off_preset: Dout = preset_q;
      c_off_count:  Dout = count_q;
      default:      Dout = 32'd0;
    endcase
  end

  assign IRQ = irq_flag_q & ctrl_q[c_bit_im];

endmodule
`default_nettype wire
